// File: rtl/regfile_read_arbiter.sv
// Shares one register read port among NUM_REQ requesters via a registered select bus.
// Latency: req sampled at edge t -> gnt in t+1 -> rd_valid/rd_data in t+3; one read per 3 cycles.
// Backpressure: requesters hold req until gnt; FIXED_PRIO_EN selects fixed priority instead of round-robin.
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         port_sel,
    input  logic [DATA_W-1:0]         port_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PTR_W-1:0] r_owner;
    logic [PTR_W-1:0] w_win;
    logic             w_found;
`ifndef FIXED_PRIO_EN
    logic [PTR_W-1:0] r_ptr;
`endif

    // Descending scan: the last hit written is the highest-priority candidate.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
`ifdef FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[PTR_W'(k)]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(k);
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int               idx;
            logic [PTR_W-1:0] cand;
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = PTR_W'(idx);
            if (req[cand]) begin
                w_found = 1'b1;
                w_win   = cand;
            end
        end
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = SETTLE;
            SETTLE:  w_next = CAPTURE;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt      <= '0;
            rd_valid <= '0;
            port_sel <= '0;
            rd_data  <= '0;
            r_owner  <= '0;
`ifndef FIXED_PRIO_EN
            r_ptr    <= '0;
`endif
        end else begin
            gnt      <= '0;
            rd_valid <= '0;
            if (r_state == IDLE && w_found) begin
                gnt      <= ONE_HOT0 << w_win;
                port_sel <= addr[int'(w_win)*ADDR_W +: ADDR_W];
                r_owner  <= w_win;
            end
            if (r_state == CAPTURE) begin
                rd_data  <= port_data;
                rd_valid <= ONE_HOT0 << r_owner;
`ifndef FIXED_PRIO_EN
                r_ptr    <= (r_owner == PTR_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
`endif
            end
        end
    end

    assign busy = (r_state != IDLE);

endmodule
